rgmii_rx_speed_adapter: RTL and testbench
=========================================

RGMII_RX_SPEED_ADAPTER -- requirements
Module: rgmii_rx_speed_adapter

Interface
REQ-001 Parameters: none; speed is a runtime input.
REQ-002 clk  in  1  RGMII receive clock after the DDR capture stage: 125/25/2.5 MHz at 1000/100/10M.
REQ-003 rst_n  in  1  Reset, asynchronous and active-low.
REQ-004 rx_q1  in  4  Nibble captured on the rising edge.
REQ-005 rx_q2  in  4  Nibble captured on the falling edge.
REQ-006 rx_ctl_1  in  1  RX_CTL captured on the rising edge (DV).
REQ-007 rx_ctl_2  in  1  RX_CTL captured on the falling edge (DV xor ER).
REQ-008 speed  in  2  00=10M, 01=100M, 1x=1000M.
REQ-009 gmii_rxd  out  8  Assembled receive byte.
REQ-010 gmii_rx_dv  out  1  Byte valid.
REQ-011 gmii_rx_er  out  1  Byte error.
REQ-012 gmii_rx_clk_en  out  1  One-cycle qualifier; the MAC samples the GMII outputs only when it is high.
REQ-013 inband_link_up  out  1  Decoded link status.
REQ-014 inband_speed  out  2  Decoded PHY speed code.
REQ-015 inband_full_duplex  out  1  Decoded duplex.
REQ-016 inband_valid  out  1  In-band status has been decoded at least once since reset.
REQ-017 odd_nibble_count  out  8  Saturating count of frames that ended on an odd nibble.

Function
REQ-018 Define er_n = rx_ctl_1 ^ rx_ctl_2 in every mode.
REQ-019 1000M: every cycle, register rxd={rx_q2,rx_q1}, dv=rx_ctl_1, er=er_n, clk_en=1.
REQ-020 1000M: latency is 1 cycle from input to output.
REQ-021 10/100M: each cycle carries one nibble, which is rx_q1; rx_q2 is ignored for data.
REQ-022 10/100M: an FSM with states IDLE, LOW and HIGH assembles nibbles, low nibble first.
REQ-023 IDLE: clk_en pulses every second cycle with dv=0, er=0, rxd=0.
REQ-024 IDLE: rx_ctl_1=1 latches the nibble as the low nibble, clears sfd_seen, and moves to HIGH.
REQ-025 HIGH with rx_ctl_1=1: on the next cycle, output rxd={nibble,low}, dv=1, er=OR of both nibbles' er_n, clk_en=1; move to LOW.
REQ-026 HIGH with rx_ctl_1=0 (odd end): output rxd={4'h0,low}, dv=1, er=1, clk_en=1; increment odd_nibble_count (saturating at 255); move to IDLE.
REQ-027 LOW with rx_ctl_1=1: latch the low nibble; move to HIGH.
REQ-028 LOW with rx_ctl_1=0: frame ends with no extra byte; move to IDLE.
REQ-029 SFD realignment: in LOW with sfd_seen=0, nibble=4'hD and previous nibble=4'h5 -> output byte 8'hD5 (dv=1, clk_en=1), set sfd_seen, stay in LOW.
REQ-030 A byte 8'hD5 assembled in HIGH also sets sfd_seen.
REQ-031 Once sfd_seen=1, no realignment occurs until the next frame.
REQ-032 In-band status: when rx_ctl_1=0, rx_ctl_2=0 and rx_q1==rx_q2 with the same value for 2 consecutive cycles, update link=q1[0], speed=q1[2:1], duplex=q1[3], and set inband_valid=1.
REQ-033 In-band status decoding is active in all modes.
REQ-034 In-band outputs hold their value at all other times; frames do not affect them.
REQ-035 A change of speed is detected by comparing against a registered copy.
REQ-036 Speed change in HIGH/LOW: emit one cycle with dv=1, er=1, clk_en=1, rxd=0, then enter IDLE.
REQ-037 Speed change in IDLE or in 1000M: no abort byte is emitted; the new mode takes effect the next cycle.
REQ-038 Outputs are registered; in 10/100M, gmii_rxd/dv/er hold their value between clk_en pulses.

Reset
REQ-039 While rst_n=0, all outputs are 0, the FSM is in IDLE, sfd_seen=0, the idle toggle is 0, and the stored speed is 00.
REQ-040 Reset asserted mid-frame discards the partial byte; no abort byte is emitted.
REQ-041 After rst_n deasserts, the first output appears no earlier than the next clk edge.

Verification
REQ-042 1000M: q1=5, q2=5, ctl=1/1 for 7 cycles, then q1=5, q2=D -> 7 bytes 0x55 then 0xD5, dv=1, er=0, clk_en continuously 1, latency 1 cycle.
REQ-043 100M: nibbles 5x15, D, then A,B with ctl_1=1 -> bytes 0x55x7, 0xD5, 0xBA at alternate cycles, er=0.
REQ-044 100M misaligned: nibbles 5x14, D, 1, 2 -> 0x55x7, realigned 0xD5, 0x21; no odd-end error.
REQ-045 10M frame of 9 nibbles, ctl_1 dropping after the 9th -> last byte {0,n9} with er=1; odd_nibble_count increments 0->1.
REQ-046 Idle with q1=q2=4'hD, ctl=0/0 for 2 cycles -> link=1, speed=10, duplex=1, inband_valid=1.
REQ-047 Speed changed 01->1x mid-frame -> one byte with dv=1, er=1, then 1000M pass-through.

Source files
------------

// File: rtl/rgmii_rx_speed_adapter.sv
// RGMII receive speed adapter: DDR-captured nibbles to GMII bytes at 10/100/1000M,
// with in-band link status decoding and odd-nibble frame accounting.
`timescale 1ns/1ps
module rgmii_rx_speed_adapter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rx_q1,
    input  logic [3:0] rx_q2,
    input  logic       rx_ctl_1,
    input  logic       rx_ctl_2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_clk_en,
    output logic       inband_link_up,
    output logic [1:0] inband_speed,
    output logic       inband_full_duplex,
    output logic       inband_valid,
    output logic [7:0] odd_nibble_count
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NIB_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_e;

    state_e            state_q, state_d;
    logic [NIB_W-1:0]  low_q, low_d;
    logic              low_er_q, low_er_d;
    logic              sfd_q, sfd_d;
    logic              tog_q, tog_d;
    logic [1:0]        speed_q;
    logic [NIB_W-1:0]  prev_nib_q;
    logic              prev_er_q;
    logic [BYTE_W-1:0] rxd_q, rxd_d;
    logic              dv_q, dv_d, er_q, er_d, clk_en_q, clk_en_d;
    logic [BYTE_W-1:0] odd_q, odd_d;
    logic              ib_cand_q;
    logic [NIB_W-1:0]  ib_val_q;
    logic              ib_link_q, ib_dup_q, ib_valid_q;
    logic [1:0]        ib_speed_q;

    logic er_n, spd_chg, ib_cand, ib_hit;

    assign er_n    = rx_ctl_1 ^ rx_ctl_2;
    assign spd_chg = (speed != speed_q);
    assign ib_cand = !rx_ctl_1 && !rx_ctl_2 && (rx_q1 == rx_q2);
    assign ib_hit  = ib_cand && ib_cand_q && (rx_q1 == ib_val_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            low_q      <= '0;
            low_er_q   <= 1'b0;
            sfd_q      <= 1'b0;
            tog_q      <= 1'b0;
            speed_q    <= 2'b00;
            prev_nib_q <= '0;
            prev_er_q  <= 1'b0;
            rxd_q      <= '0;
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            clk_en_q   <= 1'b0;
            odd_q      <= '0;
            ib_cand_q  <= 1'b0;
            ib_val_q   <= '0;
            ib_link_q  <= 1'b0;
            ib_speed_q <= 2'b00;
            ib_dup_q   <= 1'b0;
            ib_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            low_er_q   <= low_er_d;
            sfd_q      <= sfd_d;
            tog_q      <= tog_d;
            speed_q    <= speed;
            prev_nib_q <= rx_q1;
            prev_er_q  <= er_n;
            rxd_q      <= rxd_d;
            dv_q       <= dv_d;
            er_q       <= er_d;
            clk_en_q   <= clk_en_d;
            odd_q      <= odd_d;
            ib_cand_q  <= ib_cand;
            ib_val_q   <= rx_q1;
            // In-band status needs the same idle nibble on two consecutive cycles
            if (ib_hit) begin
                ib_link_q  <= rx_q1[0];
                ib_speed_q <= rx_q1[2:1];
                ib_dup_q   <= rx_q1[3];
                ib_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        low_d    = low_q;
        low_er_d = low_er_q;
        sfd_d    = sfd_q;
        tog_d    = tog_q;
        rxd_d    = rxd_q;
        dv_d     = dv_q;
        er_d     = er_q;
        clk_en_d = 1'b0;
        odd_d    = odd_q;
        if (speed_q[1]) begin
            state_d  = S_IDLE;
            tog_d    = 1'b0;
            rxd_d    = {rx_q2, rx_q1};
            dv_d     = rx_ctl_1;
            er_d     = er_n;
            clk_en_d = 1'b1;
        end else if (spd_chg && (state_q != S_IDLE)) begin
            // Abort a nibble-mode frame that straddles a speed change
            state_d  = S_IDLE;
            tog_d    = 1'b0;
            rxd_d    = '0;
            dv_d     = 1'b1;
            er_d     = 1'b1;
            clk_en_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_ctl_1) begin
                        low_d    = rx_q1;
                        low_er_d = er_n;
                        sfd_d    = 1'b0;
                        tog_d    = 1'b0;
                        state_d  = S_HIGH;
                    end else begin
                        tog_d = ~tog_q;
                        if (tog_q) begin
                            rxd_d    = '0;
                            dv_d     = 1'b0;
                            er_d     = 1'b0;
                            clk_en_d = 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    clk_en_d = 1'b1;
                    dv_d     = 1'b1;
                    if (rx_ctl_1) begin
                        rxd_d   = {rx_q1, low_q};
                        er_d    = low_er_q | er_n;
                        state_d = S_LOW;
                        if ({rx_q1, low_q} == 8'hD5) sfd_d = 1'b1;
                    end else begin
                        rxd_d   = {4'h0, low_q};
                        er_d    = 1'b1;
                        state_d = S_IDLE;
                        tog_d   = 1'b0;
                        if (odd_q != 8'hFF) odd_d = odd_q + 8'd1;
                    end
                end
                S_LOW: begin
                    if (rx_ctl_1) begin
                        // A 5 then D arriving across a byte boundary realigns on the SFD
                        if (!sfd_q && (rx_q1 == 4'hD) && (prev_nib_q == 4'h5)) begin
                            rxd_d    = 8'hD5;
                            dv_d     = 1'b1;
                            er_d     = er_n | prev_er_q;
                            clk_en_d = 1'b1;
                            sfd_d    = 1'b1;
                        end else begin
                            low_d    = rx_q1;
                            low_er_d = er_n;
                            state_d  = S_HIGH;
                        end
                    end else begin
                        state_d = S_IDLE;
                        tog_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign gmii_rxd           = rxd_q;
    assign gmii_rx_dv         = dv_q;
    assign gmii_rx_er         = er_q;
    assign gmii_rx_clk_en     = clk_en_q;
    assign inband_link_up     = ib_link_q;
    assign inband_speed       = ib_speed_q;
    assign inband_full_duplex = ib_dup_q;
    assign inband_valid       = ib_valid_q;
    assign odd_nibble_count   = odd_q;
endmodule

// File: tb/tb_rgmii_rx_speed_adapter.sv
// Directed scoreboard bench for rgmii_rx_speed_adapter.
`timescale 1ns/1ps
module tb_rgmii_rx_speed_adapter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx_q1, rx_q2;
    logic       rx_ctl_1, rx_ctl_2;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en;
    logic       inband_link_up, inband_full_duplex, inband_valid;
    logic [1:0] inband_speed;
    logic [7:0] odd_nibble_count;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #4 clk = ~clk;

    rgmii_rx_speed_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .rx_q1(rx_q1), .rx_q2(rx_q2), .rx_ctl_1(rx_ctl_1), .rx_ctl_2(rx_ctl_2),
        .speed(speed),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rx_clk_en(gmii_rx_clk_en),
        .inband_link_up(inband_link_up), .inband_speed(inband_speed),
        .inband_full_duplex(inband_full_duplex), .inband_valid(inband_valid),
        .odd_nibble_count(odd_nibble_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] q1, input logic [3:0] q2, input logic c1, input logic c2);
        rx_q1 = q1; rx_q2 = q2; rx_ctl_1 = c1; rx_ctl_2 = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] n);
        step(n, ~n, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'h0, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [7:0] d, input logic er);
        exp_t e;
        e.d = d; e.er = er;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    // Every valid byte the MAC would sample is checked against the queue
    always @(negedge clk) begin
        if (rst_n && gmii_rx_clk_en && gmii_rx_dv) begin
            exp_t e;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_byte got %h/%b exp none", gmii_rxd, gmii_rx_er);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                assert ({gmii_rxd, gmii_rx_er} === {e.d, e.er}) else begin
                    errors++;
                    $error("FAIL byte got %h/%b exp %h/%b", gmii_rxd, gmii_rx_er, e.d, e.er);
                end
            end
        end
    end

    initial begin
        int cnt;
        rst_n = 1'b0; speed = 2'b10;
        rx_q1 = 4'h0; rx_q2 = 4'hF; rx_ctl_1 = 1'b0; rx_ctl_2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rxd", gmii_rxd, 0);
        chk("rst_dv", gmii_rx_dv, 0);
        chk("rst_er", gmii_rx_er, 0);
        chk("rst_clk_en", gmii_rx_clk_en, 0);
        chk("rst_inband_valid", inband_valid, 0);
        chk("rst_odd", odd_nibble_count, 0);
        rst_n = 1'b1;
        idle(3);

        // 1000M pass-through, one-cycle latency
        repeat (7) begin
            push(8'h55, 1'b0);
            step(4'h5, 4'h5, 1'b1, 1'b1);
            chk("g_rxd", gmii_rxd, 8'h55);
            chk("g_clk_en", gmii_rx_clk_en, 1);
        end
        push(8'hD5, 1'b0);
        step(4'h5, 4'hD, 1'b1, 1'b1);
        chk("g_sfd", gmii_rxd, 8'hD5);
        chk("g_dv", gmii_rx_dv, 1);
        idle(2);
        drain("g_drain");

        // 100M idle: clk_en every second cycle
        speed = 2'b01;
        idle(3);
        cnt = 0;
        repeat (4) begin
            idle(1);
            cnt += int'(gmii_rx_clk_en);
        end
        chk("idle_pulses", cnt, 2);
        chk("idle_dv", gmii_rx_dv, 0);

        // 100M aligned frame
        for (int i = 1; i <= 15; i++) begin
            if (i % 2 == 0) push(8'h55, 1'b0);
            nib(4'h5);
        end
        push(8'hD5, 1'b0); nib(4'hD);
        nib(4'hA);
        push(8'hBA, 1'b0); nib(4'hB);
        idle(3);
        drain("m_aligned_drain");

        // 100M misaligned frame, realigned on SFD
        for (int i = 1; i <= 14; i++) begin
            if (i % 2 == 0) push(8'h55, 1'b0);
            nib(4'h5);
        end
        push(8'hD5, 1'b0); nib(4'hD);
        nib(4'h1);
        push(8'h21, 1'b0); nib(4'h2);
        idle(3);
        drain("m_realign_drain");
        chk("m_odd", odd_nibble_count, 0);

        // 10M frame of 9 nibbles, one error nibble, odd end
        speed = 2'b00;
        idle(3);
        nib(4'h1);
        push(8'h21, 1'b0); nib(4'h2);
        nib(4'h3);
        push(8'h43, 1'b1); step(4'h4, 4'h0, 1'b1, 1'b0);
        nib(4'h5);
        push(8'h65, 1'b0); nib(4'h6);
        nib(4'h7);
        push(8'h87, 1'b0); nib(4'h8);
        nib(4'h9);
        push(8'h09, 1'b1); idle(1);
        chk("odd_count", odd_nibble_count, 1);
        idle(3);
        drain("t_drain");

        // In-band status decode
        chk("ib_before", inband_valid, 0);
        step(4'hD, 4'hD, 1'b0, 1'b0);
        chk("ib_one_cycle", inband_valid, 0);
        step(4'hD, 4'hD, 1'b0, 1'b0);
        chk("ib_valid", inband_valid, 1);
        chk("ib_link", inband_link_up, 1);
        chk("ib_speed", inband_speed, 2'b10);
        chk("ib_duplex", inband_full_duplex, 1);
        step(4'h2, 4'h2, 1'b0, 1'b0);
        idle(2);
        chk("ib_hold_link", inband_link_up, 1);
        chk("ib_hold_speed", inband_speed, 2'b10);

        // Speed change mid-frame: abort byte then 1000M
        speed = 2'b01;
        idle(3);
        nib(4'h5);
        push(8'h55, 1'b0); nib(4'h5);
        nib(4'h5);
        speed = 2'b10;
        push(8'h00, 1'b1); nib(4'h5);
        chk("abort_dv", gmii_rx_dv, 1);
        chk("abort_er", gmii_rx_er, 1);
        push(8'hD5, 1'b0); step(4'h5, 4'hD, 1'b1, 1'b1);
        chk("post_abort_rxd", gmii_rxd, 8'hD5);
        idle(2);
        drain("abort_drain");

        // Reset mid-frame discards the partial byte
        speed = 2'b01;
        idle(3);
        nib(4'h5);
        rst_n = 1'b0;
        #1;
        chk("midrst_dv", gmii_rx_dv, 0);
        chk("midrst_clk_en", gmii_rx_clk_en, 0);
        chk("midrst_odd", odd_nibble_count, 0);
        chk("midrst_ib", inband_valid, 0);
        step(4'h5, 4'hA, 1'b1, 1'b1);
        rst_n = 1'b1;
        idle(4);
        drain("midrst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
